// File: rtl/pcm_i2s_pkg.sv
// pcm_i2s_pkg -- shared definitions for the PCM/I2S transmitter and receiver.
//
// Contents:
//   LENGTH_16/24/32   legal slot lengths in BCLK cycles per channel
//   is_legal_length() true for one of the legal slot lengths
//   clog2()           ceiling log2, used to size the slot counter
//   cnt_width()       slot counter width for a frame of 2*length cycles
package pcm_i2s_pkg;

  localparam int LENGTH_16 = 16;
  localparam int LENGTH_24 = 24;
  localparam int LENGTH_32 = 32;

  function automatic bit is_legal_length(input int length);
    return (length == LENGTH_16) || (length == LENGTH_24) || (length == LENGTH_32);
  endfunction

  function automatic int clog2(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) result++;
    return result;
  endfunction

  function automatic int cnt_width(input int length);
    return clog2(2 * length);
  endfunction

endpackage

// File: rtl/pcm_i2s_holdreg.sv
// pcm_i2s_holdreg -- one-entry holding register for a left/right PCM pair.
//
// The entry fills on a valid/ready handshake and empties when the
// transmitter loads a frame. On the load cycle the entry can be refilled in
// the same edge, so a continuously valid source sees exactly one accept per
// frame.
//
// Ports:
//   clk     in   clock, registers update on the falling edge
//   rst     in   synchronous active-high reset (empties the entry)
//   load    in   frame load happens at the coming falling edge
//   valid   in   new pair offered
//   new_l   in   offered left sample
//   new_r   in   offered right sample
//   ready   out  pair will be accepted at the coming falling edge
//   full    out  entry holds a pair
//   held_l  out  held left sample
//   held_r  out  held right sample
module pcm_i2s_holdreg
  import pcm_i2s_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         load,
  input  logic                         valid,
  input  logic signed [DATA_WIDTH-1:0] new_l,
  input  logic signed [DATA_WIDTH-1:0] new_r,
  output logic                         ready,
  output logic                         full,
  output logic signed [DATA_WIDTH-1:0] held_l,
  output logic signed [DATA_WIDTH-1:0] held_r
);

  logic accept;

  // A full entry can still take a pair on the load edge, because the
  // current contents move into the shift register on that same edge.
  assign ready  = !rst && (!full || load);
  assign accept = valid && ready;

  always_ff @(negedge clk) begin
    if (rst) begin
      full <= 1'b0;
    end else if (accept) begin
      full <= 1'b1;
    end else if (load) begin
      full <= 1'b0;
    end
  end

  // Sample storage is qualified by full, so it needs no reset.
  always_ff @(negedge clk) begin
    if (accept) begin
      held_l <= new_l;
      held_r <= new_r;
    end
  end

endmodule

// File: rtl/pcm_i2s_tx.sv
// pcm_i2s_tx -- PCM to I2S serial transmitter, BCLK-domain only.
//
// Each frame is 2*LENGTH BCLK cycles: left slot while LRCK_O is 0, right
// slot while LRCK_O is 1. Samples are MSB-justified in their slot and zero
// padded below. A frame is loaded when the slot counter wraps; an empty
// holding register or active mute loads an all-zero frame.
//
// Parameters:
//   LENGTH      BCLK cycles per slot (16, 24 or 32)
//   DATA_WIDTH  PCM sample width, DATA_WIDTH <= LENGTH
//
// Ports:
//   BCLK_I      in   bit clock, all registers update on the falling edge
//   RESET_I     in   synchronous active-high reset
//   PCML_I      in   left sample, signed
//   PCMR_I      in   right sample, signed
//   VALID_I     in   sample pair valid
//   READY_O     out  sample pair accepted when VALID_I && READY_O at an edge
//   MUTEN_I     in   mute, active-low, sampled only at the frame load
//   LRCK_O      out  word clock, 0 = left slot, 1 = right slot
//   DATA_O      out  serial data, MSB first
//   FRAME_O     out  pulse during the first cycle of each frame
//   UNDERRUN_O  out  pulse during the first cycle of a frame loaded empty
//
// Build option:
//   PCM_I2S_TX_LEFT_JUSTIFIED_EN  left-justified format (no one-bit delay);
//                                 default is I2S with a one-bit delay.
module pcm_i2s_tx
  import pcm_i2s_pkg::*;
#(
  parameter int LENGTH     = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                         BCLK_I,
  input  logic                         RESET_I,
  input  logic signed [DATA_WIDTH-1:0] PCML_I,
  input  logic signed [DATA_WIDTH-1:0] PCMR_I,
  input  logic                         VALID_I,
  output logic                         READY_O,
  input  logic                         MUTEN_I,
  output logic                         LRCK_O,
  output logic                         DATA_O,
  output logic                         FRAME_O,
  output logic                         UNDERRUN_O
);

  localparam int             CW    = cnt_width(LENGTH);
  localparam int             FW    = 2 * LENGTH;
  localparam logic [CW-1:0]  LAST  = CW'(FW - 1);
  localparam logic [CW-1:0]  HALF  = CW'(LENGTH);

  logic [CW-1:0]                cnt;
  logic                         last;
  logic                         full;
  logic signed [DATA_WIDTH-1:0] held_l;
  logic signed [DATA_WIDTH-1:0] held_r;
  logic [LENGTH-1:0]            slot_l;
  logic [LENGTH-1:0]            slot_r;
  logic [FW-1:0]                frame;
  logic [FW-1:0]                shift_p0;

  assign last   = (cnt == LAST);
  assign LRCK_O = (cnt >= HALF);

  pcm_i2s_holdreg #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_holdreg (
    .clk    (BCLK_I),
    .rst    (RESET_I),
    .load   (last),
    .valid  (VALID_I),
    .new_l  (PCML_I),
    .new_r  (PCMR_I),
    .ready  (READY_O),
    .full   (full),
    .held_l (held_l),
    .held_r (held_r)
  );

  // Mute and emptiness are both decided here, at load time only, so a mute
  // change mid-frame never disturbs bits already in the shift register.
  always_comb begin
    slot_l = '0;
    slot_r = '0;
    if (full && MUTEN_I) begin
      slot_l[LENGTH-1 -: DATA_WIDTH] = held_l;
      slot_r[LENGTH-1 -: DATA_WIDTH] = held_r;
    end
    frame = {slot_l, slot_r};
  end

  // Stage p0: slot counter, frame shift register and status pulses
  always_ff @(negedge BCLK_I) begin
    if (RESET_I) begin
      cnt        <= LAST;
      shift_p0   <= '0;
      FRAME_O    <= 1'b0;
      UNDERRUN_O <= 1'b0;
    end else begin
      cnt        <= last ? '0 : cnt + CW'(1);
      shift_p0   <= last ? frame : (shift_p0 << 1);
      FRAME_O    <= last;
      UNDERRUN_O <= last && !full;
    end
  end

`ifdef PCM_I2S_TX_LEFT_JUSTIFIED_EN
  // Left-justified: frame bit k is at the top of the shift register during
  // cnt = k, so the left MSB coincides with LRCK_O falling.
  assign DATA_O = shift_p0[FW-1];
`else
  // Stage p1: one-bit I2S delay. The top bit is registered once more, so
  // frame bit k-1 appears during cnt = k and the last bit of a frame
  // appears during cnt = 0 of the next one.
  logic data_p1;

  always_ff @(negedge BCLK_I) begin
    if (RESET_I) begin
      data_p1 <= 1'b0;
    end else begin
      data_p1 <= shift_p0[FW-1];
    end
  end

  assign DATA_O = data_p1;
`endif

endmodule

// File: tb/tb_pcm_i2s_tx.sv
module tb_pcm_i2s_tx;

`ifdef PCM_I2S_TX_LEFT_JUSTIFIED_EN
  localparam bit LJ = 1'b1;
`else
  localparam bit LJ = 1'b0;
`endif

  logic clk = 1'b1;
  always #5 clk = ~clk;

  logic               rst    = 1'b1;
  logic               valid  = 1'b0;
  logic               muten  = 1'b1;
  logic signed [31:0] pcml   = '0;
  logic signed [31:0] pcmr   = '0;
  logic signed [23:0] pcml24 = '0;
  logic signed [23:0] pcmr24 = '0;

  logic ready, lrck, data, frame, underrun;
  logic ready24, lrck24, data24, frame24, underrun24;

  int total  = 0;
  int passed = 0;

  pcm_i2s_tx #(.LENGTH(32), .DATA_WIDTH(32)) dut (
    .BCLK_I(clk), .RESET_I(rst), .PCML_I(pcml), .PCMR_I(pcmr),
    .VALID_I(valid), .READY_O(ready), .MUTEN_I(muten), .LRCK_O(lrck),
    .DATA_O(data), .FRAME_O(frame), .UNDERRUN_O(underrun)
  );

  pcm_i2s_tx #(.LENGTH(32), .DATA_WIDTH(24)) dut24 (
    .BCLK_I(clk), .RESET_I(rst), .PCML_I(pcml24), .PCMR_I(pcmr24),
    .VALID_I(valid), .READY_O(ready24), .MUTEN_I(muten), .LRCK_O(lrck24),
    .DATA_O(data24), .FRAME_O(frame24), .UNDERRUN_O(underrun24)
  );

  // Advance to the next rising edge at which FRAME_O is high (cnt == 0).
  task automatic wait_frame();
    int n;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (!frame && n < 200);
    if (!frame) begin
      total++;
      $display("FAIL wait_frame: no FRAME_O within %0d cycles", n);
    end
  endtask

  // Offer a pair, hold VALID_I until it is taken at a falling edge.
  task automatic send_pair(input logic [31:0] l, input logic [31:0] r,
                           input logic [23:0] l24, input logic [23:0] r24);
    int n;
    pcml = l; pcmr = r; pcml24 = l24; pcmr24 = r24;
    valid = 1'b1;
    n = 0;
    while (!ready && n < 200) begin
      @(posedge clk);
      n++;
    end
    total++;
    if (ready !== 1'b1) $display("FAIL send_accept: READY_O=%b required 1", ready);
    else passed++;
    @(posedge clk);
    valid = 1'b0;
  endtask

  // Called at the rising edge where cnt == 0; returns frame bit i at [63-i].
  task automatic capture(output logic [63:0] f, output logic [63:0] g);
    f = '0;
    g = '0;
    if (LJ) begin
      f[63] = data;
      g[63] = data24;
      for (int i = 1; i < 64; i++) begin
        @(posedge clk);
        f[63-i] = data;
        g[63-i] = data24;
      end
    end else begin
      for (int i = 0; i < 64; i++) begin
        @(posedge clk);
        f[63-i] = data;
        g[63-i] = data24;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    total++; if (lrck !== 1'b1) $display("FAIL reset_lrck: got %b required 1", lrck); else passed++;
    total++; if (data !== 1'b0) $display("FAIL reset_data: got %b required 0", data); else passed++;
    total++; if (frame !== 1'b0) $display("FAIL reset_frame: got %b required 0", frame); else passed++;
    total++; if (underrun !== 1'b0) $display("FAIL reset_underrun: got %b required 0", underrun); else passed++;
    total++; if (ready !== 1'b0) $display("FAIL reset_ready: got %b required 0", ready); else passed++;
    rst = 1'b0;
    @(posedge clk);
    total++; if (frame !== 1'b1) $display("FAIL release_frame: got %b required 1", frame); else passed++;
    total++; if (underrun !== 1'b1) $display("FAIL release_underrun: got %b required 1", underrun); else passed++;
    total++; if (lrck !== 1'b0) $display("FAIL release_lrck: got %b required 0", lrck); else passed++;
    total++; if (ready !== 1'b1) $display("FAIL release_ready: got %b required 1", ready); else passed++;
  endtask

  // Two idle frames observed from cnt = 1 through cnt = 0 of the third.
  task automatic test_idle();
    int frames, unds, ones, lows;
    frames = 0; unds = 0; ones = 0; lows = 0;
    for (int i = 1; i <= 128; i++) begin
      @(posedge clk);
      frames += int'(frame);
      unds   += int'(underrun);
      ones   += int'(data) + int'(data24);
      lows   += int'(!lrck);
      if (frame && (i % 64) != 0) begin
        total++;
        $display("FAIL idle_frame_spacing: FRAME_O at offset %0d required multiple of 64", i);
      end
    end
    total++; if (frames !== 2) $display("FAIL idle_frames: got %0d required 2", frames); else passed++;
    total++; if (unds !== 2) $display("FAIL idle_underruns: got %0d required 2", unds); else passed++;
    total++; if (ones !== 0) $display("FAIL idle_data: got %0d ones required 0", ones); else passed++;
    total++; if (lows !== 64) $display("FAIL idle_lrck_low: got %0d required 64", lows); else passed++;
  endtask

  task automatic test_pattern();
    logic [63:0] f, g, exp32, exp24;
    exp32 = {32'h8000_0001, 32'h7FFF_FFFE};
    exp24 = {24'hABCDEF, 8'h00, 24'h123456, 8'h00};
    wait_frame();
    send_pair(32'h8000_0001, 32'h7FFF_FFFE, 24'hABCDEF, 24'h123456);
    wait_frame();
    total++; if (underrun !== 1'b0) $display("FAIL pattern_underrun: got %b required 0", underrun); else passed++;
    capture(f, g);
    total++; if (f !== exp32) $display("FAIL pattern_frame32: got %h required %h", f, exp32); else passed++;
    total++; if (f[63] !== 1'b1) $display("FAIL pattern_l_msb: got %b required 1", f[63]); else passed++;
    total++; if (f[32] !== 1'b1) $display("FAIL pattern_l_lsb: got %b required 1", f[32]); else passed++;
    total++; if (f[31] !== 1'b0) $display("FAIL pattern_r_msb: got %b required 0", f[31]); else passed++;
    total++; if (g !== exp24) $display("FAIL pattern_frame24: got %h required %h", g, exp24); else passed++;
  endtask

  task automatic test_back_to_back();
    int acc, bad, frames, unds;
    logic [63:0] f, g, exp32;
    exp32 = {32'h1234_5678, 32'hFEDC_BA98};
    acc = 0; bad = 0; frames = 0; unds = 0;
    wait_frame();
    pcml = 32'h1234_5678; pcmr = 32'hFEDC_BA98; pcml24 = 24'h111111; pcmr24 = 24'h222222;
    valid = 1'b1;
    for (int j = 0; j < 192; j++) begin
      if (j > 0) @(posedge clk);
      acc += int'(ready);
      if (ready && (j % 64) != 0 && (j % 64) != 63) bad++;
      if ((j % 64) == 0 && j > 0) begin
        frames += int'(frame);
        unds   += int'(underrun);
      end
    end
    @(posedge clk);
    valid = 1'b0;
    total++; if (acc !== 4) $display("FAIL b2b_accepts: got %0d required 4", acc); else passed++;
    total++; if (bad !== 0) $display("FAIL b2b_ready_midframe: got %0d required 0", bad); else passed++;
    total++; if (frames !== 2) $display("FAIL b2b_frames: got %0d required 2", frames); else passed++;
    total++; if (unds !== 0) $display("FAIL b2b_underruns: got %0d required 0", unds); else passed++;
    capture(f, g);
    total++; if (f !== exp32) $display("FAIL b2b_frame: got %h required %h", f, exp32); else passed++;
  endtask

  task automatic test_mute();
    logic [63:0] f, g, exp32;
    exp32 = {32'hC000_0003, 32'h0000_0005};
    wait_frame();
    send_pair(32'hA5A5_A5A5, 32'h5A5A_5A5A, 24'hA5A5A5, 24'h5A5A5A);
    muten = 1'b0;
    wait_frame();
    total++; if (underrun !== 1'b0) $display("FAIL mute_underrun: got %b required 0", underrun); else passed++;
    total++; if (ready !== 1'b1) $display("FAIL mute_ready: got %b required 1", ready); else passed++;
    muten = 1'b1;
    capture(f, g);
    total++; if (f !== 64'd0) $display("FAIL mute_frame: got %h required 0", f); else passed++;
    total++; if (g !== 64'd0) $display("FAIL mute_frame24: got %h required 0", g); else passed++;
    // Mute raised just after a load must not touch the frame in flight.
    wait_frame();
    send_pair(32'hC000_0003, 32'h0000_0005, 24'hC00003, 24'h000005);
    wait_frame();
    muten = 1'b0;
    capture(f, g);
    muten = 1'b1;
    total++; if (f !== exp32) $display("FAIL mute_midframe: got %h required %h", f, exp32); else passed++;
  endtask

  task automatic test_reset_mid();
    logic [63:0] f, g, exp32;
    exp32 = {32'h8000_0000, 32'h0000_0001};
    wait_frame();
    send_pair(32'hFFFF_0000, 32'h0000_FFFF, 24'hFF0000, 24'h00FFFF);
    repeat (39) @(posedge clk);
    total++; if (lrck !== 1'b1) $display("FAIL mid_lrck_cnt40: got %b required 1", lrck); else passed++;
    rst = 1'b1;
    @(posedge clk);
    total++; if (lrck !== 1'b1) $display("FAIL mid_reset_lrck: got %b required 1", lrck); else passed++;
    total++; if (data !== 1'b0) $display("FAIL mid_reset_data: got %b required 0", data); else passed++;
    total++; if (frame !== 1'b0) $display("FAIL mid_reset_frame: got %b required 0", frame); else passed++;
    total++; if (underrun !== 1'b0) $display("FAIL mid_reset_underrun: got %b required 0", underrun); else passed++;
    total++; if (ready !== 1'b0) $display("FAIL mid_reset_ready: got %b required 0", ready); else passed++;
    rst = 1'b0;
    @(posedge clk);
    total++; if (frame !== 1'b1) $display("FAIL mid_release_frame: got %b required 1", frame); else passed++;
    total++; if (underrun !== 1'b1) $display("FAIL mid_release_underrun: got %b required 1", underrun); else passed++;
    total++; if (lrck !== 1'b0) $display("FAIL mid_release_lrck: got %b required 0", lrck); else passed++;
    capture(f, g);
    total++; if (f !== 64'd0) $display("FAIL mid_pair_lost: got %h required 0", f); else passed++;
    wait_frame();
    send_pair(32'h8000_0000, 32'h0000_0001, 24'h800000, 24'h000001);
    wait_frame();
    total++;
    if (data !== LJ) $display("FAIL msb_at_cnt0: got %b required %b", data, LJ);
    else passed++;
    capture(f, g);
    total++; if (f !== exp32) $display("FAIL after_reset_frame: got %h required %h", f, exp32); else passed++;
  endtask

  initial begin
    test_reset();
    test_idle();
    test_pattern();
    test_back_to_back();
    test_mute();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pcm_i2s_tx.md
PCM_I2S_TX -- requirements
Module: pcm_i2s_tx

Interface
REQ-001 Parameter LENGTH, default 32, meaning BCLK cycles per channel slot, so one frame is 2*LENGTH cycles; legal values 16, 24, 32.
REQ-002 Parameter DATA_WIDTH, default 32, meaning PCM sample width; SHALL satisfy DATA_WIDTH <= LENGTH.
REQ-003 BCLK_I  in  1  sole clock; all registers SHALL update on the falling edge.
REQ-004 RESET_I  in  1  reset; synchronous, active-high, sampled on the falling edge of BCLK_I.
REQ-005 PCML_I  in  DATA_WIDTH  left sample, signed two's complement.
REQ-006 PCMR_I  in  DATA_WIDTH  right sample, signed two's complement.
REQ-007 VALID_I  in  1  sample pair valid.
REQ-008 READY_O  out  1  sample pair accepted when VALID_I and READY_O are both high at a falling edge.
REQ-009 MUTEN_I  in  1  mute, active-low.
REQ-010 LRCK_O  out  1  word clock: 0 = left slot, 1 = right slot.
REQ-011 DATA_O  out  1  serial data, MSB first.
REQ-012 FRAME_O  out  1  one-cycle pulse on the cycle a frame is loaded.
REQ-013 UNDERRUN_O  out  1  one-cycle pulse when a frame load finds no sample.

Function
REQ-014 Slot counter cnt SHALL run 0..2*LENGTH-1 and wrap to 0; LRCK_O SHALL equal (cnt >= LENGTH).
REQ-015 The one-entry holding register SHALL fill on an accepted handshake and SHALL empty on a frame load.
- READY_O = !full || (cnt == 2*LENGTH-1).
- Simultaneous load and accept: the held pair is loaded and the new pair enters the holding register.
REQ-016 Frame load SHALL occur on the edge where cnt goes 2*LENGTH-1 -> 0.
- The shift register receives {PCML, zeros, PCMR, zeros}: each sample is MSB-justified in its LENGTH-bit slot with zero padding below.
- FRAME_O SHALL be high during cnt == 0.
REQ-017 If the holding register is empty at a load, the frame SHALL be all zeros and UNDERRUN_O SHALL be high during cnt == 0.
REQ-018 If MUTEN_I is 0 at a load, the frame SHALL be all zeros and the held pair SHALL still be consumed; UNDERRUN_O SHALL NOT assert for a muted load with data present.
REQ-019 A MUTEN_I change mid-frame SHALL NOT affect the frame in progress.
REQ-020 I2S timing: during cnt = k (1..2*LENGTH-1), DATA_O SHALL carry frame bit k-1; during cnt = 0, DATA_O SHALL carry bit 2*LENGTH-1 of the previous frame.
REQ-021 Left MSB SHALL therefore appear one BCLK after LRCK_O falls, and right MSB one BCLK after LRCK_O rises.

Reset
REQ-022 While RESET_I is high, the following values SHALL hold:
- cnt = 2*LENGTH-1 and LRCK_O = 1.
- DATA_O = 0, FRAME_O = 0, UNDERRUN_O = 0, READY_O = 0.
- Holding register empty; shift register all zeros.
REQ-023 The first falling edge after RESET_I deasserts SHALL perform a frame load, with cnt -> 0. With no sample held, this is an underrun frame.
REQ-024 Reset asserted mid-frame SHALL discard the frame in progress and the held pair at the next falling edge.

Configuration
REQ-025 Macro PCM_I2S_TX_LEFT_JUSTIFIED_EN selects the serial format.
- When defined: left-justified format with no one-bit delay; DATA_O during cnt = k SHALL carry frame bit k, with left MSB coincident with LRCK_O falling.
- When undefined: I2S timing per REQ-020.
- All other behaviour SHALL be identical in both builds.

Structure
REQ-026 Package pcm_i2s_pkg SHALL hold the legal LENGTH values and the counter-width function clog2(2*LENGTH). The receiver and transmitter share this package.
REQ-027 The holding register and its handshake SHALL be sub-module pcm_i2s_holdreg; slot counting, shifting and format logic stay in pcm_i2s_tx.

Verification
REQ-028 Reset release, no VALID_I -> FRAME_O and UNDERRUN_O pulse every 64 cycles, DATA_O constant 0, LRCK_O 32 low / 32 high.
REQ-029 LENGTH=32, DATA_WIDTH=32, pair L=32'h8000_0001, R=32'h7FFF_FFFE -> DATA_O: L MSB 1 at cnt=1, L LSB 1 at cnt=32, R MSB 0 at cnt=33; a loopback receiver returns the same pair.
REQ-030 DATA_WIDTH=24, LENGTH=32, L=24'hABCDEF -> cnt 1..24 carry ABCDEF MSB first, cnt 25..32 carry 0.
REQ-031 VALID_I held high continuously -> exactly one accept per frame, READY_O high only at cnt=63 once full, no UNDERRUN_O.
REQ-032 MUTEN_I=0 across a load with data held -> zero frame, pair consumed, READY_O high next cycle, no UNDERRUN_O.
REQ-033 RESET_I for one cycle at cnt=40 -> outputs at reset values on the next edge, load on the following edge, held pair lost; repeat with PCM_I2S_TX_LEFT_JUSTIFIED_EN defined -> L MSB at cnt=0.
